// File: rtl/connect_count_accumulator_pkg.sv
// Shared constants and the batch-result record for the connect-count accumulator.
package connect_count_accumulator_pkg;

  localparam int unsigned SUM_WIDTH_DEFAULT   = 64;
  localparam int unsigned COUNT_WIDTH_DEFAULT = 32;
  localparam int unsigned CONNECT_COUNT_WIDTH = 6;
  localparam int unsigned ACCUM_LATENCY       = 4;

  typedef struct packed {
    logic [SUM_WIDTH_DEFAULT-1:0]   sum;
    logic [COUNT_WIDTH_DEFAULT-1:0] count;
  } batchResult_t;

endpackage

// File: rtl/connect_count_accumulator_split_adder.sv
// Two-stage accumulator: the low half adds in stage A and registers its carry,
// the high half adds the carry in stage B. A closing slot restarts both halves from 0.
module pipelined_split_adder
  import connect_count_accumulator_pkg::*;
#(
  parameter int unsigned WIDTH = SUM_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] addend,
  input  logic             close,
  output logic [WIDTH-1:0] sum,
  output logic             sumValid
);

  localparam int unsigned LO_W = WIDTH / 2;
  localparam int unsigned HI_W = WIDTH - LO_W;

  logic [LO_W-1:0] loAcc;
  logic [LO_W-1:0] loBase;
  logic [LO_W:0]   loNext;
  logic            carryR;
  logic [HI_W-1:0] hiTermR;
  logic [HI_W-1:0] hiAcc;
  logic [HI_W-1:0] hiBase;
  logic [HI_W-1:0] hiNext;
  logic            closeR;
  logic            hiClosed;

  // Each half restarts one cycle after its half of the closing slot has been added,
  // so the next slot begins a fresh batch with no bubble.
  always_comb begin
    loBase = closeR ? '0 : loAcc;
    hiBase = hiClosed ? '0 : hiAcc;
    loNext = {1'b0, loBase} + {1'b0, addend[LO_W-1:0]};
    hiNext = hiBase + hiTermR + HI_W'(carryR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      loAcc    <= '0;
      carryR   <= 1'b0;
      hiTermR  <= '0;
      hiAcc    <= '0;
      closeR   <= 1'b0;
      hiClosed <= 1'b0;
    end else begin
      loAcc    <= loNext[LO_W-1:0];
      carryR   <= loNext[LO_W];
      hiTermR  <= addend[WIDTH-1:LO_W];
      closeR   <= close;
      hiAcc    <= hiNext;
      hiClosed <= closeR;
    end
  end

  assign sum      = {hiNext, loAcc};
  assign sumValid = closeR;

endmodule

// File: rtl/connect_count_accumulator.sv
// Sums 2^connectCount and counts valid results per batch behind a valid/ready register.
// Optional ACCUM_DEBUG_COUNTERS_EN adds free-running totalValid/totalBatches outputs.
module connect_count_accumulator
  import connect_count_accumulator_pkg::*;
#(
  parameter int unsigned SUM_WIDTH   = SUM_WIDTH_DEFAULT,
  parameter int unsigned COUNT_WIDTH = COUNT_WIDTH_DEFAULT
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           resultValid,
  input  logic [CONNECT_COUNT_WIDTH-1:0] connectCount,
  input  logic                           batchDone,
  input  logic                           eccIn,
  output logic [SUM_WIDTH-1:0]           sumOut,
  output logic [COUNT_WIDTH-1:0]         countOut,
  output logic                           outValid,
  input  logic                           outReady,
  output logic                           eccError,
  output logic                           overflowError
`ifdef ACCUM_DEBUG_COUNTERS_EN
  ,
  output logic [31:0]                    totalValid,
  output logic [31:0]                    totalBatches
`endif
);

  logic                           s0Valid;
  logic [CONNECT_COUNT_WIDTH-1:0] s0Count;
  logic                           s0Done;
  logic                           s0Ecc;

  logic [SUM_WIDTH-1:0]           s1Term;
  logic [COUNT_WIDTH-1:0]         s1Inc;
  logic                           s1Done;

  logic [SUM_WIDTH-1:0]           batchSum;
  logic [COUNT_WIDTH-1:0]         batchCount;
  logic                           sumDone;
  logic                           countDone;
  logic                           load;

  always_ff @(posedge clk) begin
    if (rst) begin
      s0Valid  <= 1'b0;
      s0Count  <= '0;
      s0Done   <= 1'b0;
      s0Ecc    <= 1'b0;
      s1Term   <= '0;
      s1Inc    <= '0;
      s1Done   <= 1'b0;
      eccError <= 1'b0;
    end else begin
      s0Valid  <= resultValid;
      s0Count  <= connectCount;
      s0Done   <= batchDone;
      s0Ecc    <= eccIn;
      s1Term   <= s0Valid ? (SUM_WIDTH'(1) << s0Count) : '0;
      s1Inc    <= COUNT_WIDTH'(s0Valid);
      s1Done   <= s0Done;
      eccError <= eccError | s0Ecc;
    end
  end

  pipelined_split_adder #(.WIDTH(SUM_WIDTH)) sumAdder (
    .clk      (clk),
    .rst      (rst),
    .addend   (s1Term),
    .close    (s1Done),
    .sum      (batchSum),
    .sumValid (sumDone)
  );

  pipelined_split_adder #(.WIDTH(COUNT_WIDTH)) countAdder (
    .clk      (clk),
    .rst      (rst),
    .addend   (s1Inc),
    .close    (s1Done),
    .sum      (batchCount),
    .sumValid (countDone)
  );

  assign load = sumDone & countDone;

  // A closing batch that finds the register still occupied and not being read is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      sumOut        <= '0;
      countOut      <= '0;
      outValid      <= 1'b0;
      overflowError <= 1'b0;
    end else if (load) begin
      if (outValid && !outReady) begin
        overflowError <= 1'b1;
      end else begin
        sumOut   <= batchSum;
        countOut <= batchCount;
        outValid <= 1'b1;
      end
    end else if (outValid && outReady) begin
      outValid <= 1'b0;
    end
  end

`ifdef ACCUM_DEBUG_COUNTERS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      totalValid   <= '0;
      totalBatches <= '0;
    end else begin
      totalValid   <= totalValid + 32'(s0Valid);
      totalBatches <= totalBatches + 32'(s0Done);
    end
  end
`endif

endmodule
